// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: register address type, scoreboard defaults and branch-tracking states.
package mips_core_pkg;

    localparam int SB_CNT_WIDTH = 2;

    typedef logic [4:0] mips_reg_t;

    typedef enum logic {
        SB_RUN     = 1'b0,
        SB_BR_WAIT = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_counter.sv
// One saturating up/down pending-write counter: +1 issue, -1 or -2 retire/squash, clear on flush.
module sb_counter
    import mips_core_pkg::*;
#(
    parameter int W = SB_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec1,
    input  logic dec2,
    input  logic clear,
    output logic nonzero,
    output logic full,
    output logic underflow
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic [W+1:0] sum;

    // Two guard bits: bit W+1 flags a negative result, bit W an overflow past max.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d     = cnt_q;
        sum       = {2'b00, cnt_q} + (W+2)'(inc) - (W+2)'(dec1) - ((W+2)'(dec2) << 1);
        underflow = ~clear & sum[W+1];
        if (clear || sum[W+1]) begin
            cnt_d = '0;
        end else if (sum[W]) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero = |cnt_q;
    assign full    = &cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counts, one outstanding branch, stall logic.
module issue_scoreboard
    import mips_core_pkg::*;
#(
    parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      dec_valid,
    input  logic      dec_uses_rs,
    input  mips_reg_t dec_rs_addr,
    input  logic      dec_uses_rt,
    input  mips_reg_t dec_rt_addr,
    input  logic      dec_uses_rw,
    input  mips_reg_t dec_rw_addr,
    input  logic      dec_is_branch_jump,
    input  logic      dec_serialize,
    input  logic      ex_ready,
    output logic      issue_fire,
    output logic      stall,
    input  logic      wb_valid,
    input  mips_reg_t wb_rw_addr,
    input  logic      kill_valid,
    input  mips_reg_t kill_rw_addr,
    input  logic      br_resolve,
    input  logic      flush_all,
    output logic      busy,
    output logic      sb_error
);

    sb_state_e   state_q, state_d;
    logic        sb_error_q, sb_error_d;
    logic [31:0] inc_vec, dec1_vec, dec2_vec;
    logic [31:0] nonzero_vec, full_vec, underflow_vec;
    logic        raw, sat, br_block, ser;

    // Register 0 is never tracked: its status bits are tied off and its events never decode.
    assign nonzero_vec[0]   = 1'b0;
    assign full_vec[0]      = 1'b0;
    assign underflow_vec[0] = 1'b0;

    always_comb begin
        inc_vec  = '0;
        dec1_vec = '0;
        dec2_vec = '0;
        for (int r = 1; r < 32; r++) begin
            logic wb_hit, kill_hit;
            wb_hit      = wb_valid & (wb_rw_addr == 5'(r));
            kill_hit    = kill_valid & (kill_rw_addr == 5'(r));
            inc_vec[r]  = issue_fire & dec_uses_rw & (dec_rw_addr == 5'(r));
            dec1_vec[r] = wb_hit ^ kill_hit;
            dec2_vec[r] = wb_hit & kill_hit;
        end
    end

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        sb_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_vec[g]),
            .dec1      (dec1_vec[g]),
            .dec2      (dec2_vec[g]),
            .clear     (flush_all),
            .nonzero   (nonzero_vec[g]),
            .full      (full_vec[g]),
            .underflow (underflow_vec[g])
        );
    end

    assign busy     = (|nonzero_vec) | (state_q == SB_BR_WAIT);
    assign raw      = (dec_uses_rs & nonzero_vec[dec_rs_addr]) | (dec_uses_rt & nonzero_vec[dec_rt_addr]);
    assign sat      = dec_uses_rw & full_vec[dec_rw_addr];
    assign br_block = (state_q == SB_BR_WAIT);
    assign ser      = dec_serialize & busy;

    assign stall      = dec_valid & (raw | sat | br_block | ser | ~ex_ready);
    assign issue_fire = dec_valid & ~stall & ~flush_all;
    assign sb_error   = sb_error_q;

    always_comb begin
        state_d    = state_q;
        sb_error_d = sb_error_q;
        if (flush_all) begin
            state_d = SB_RUN;
        end else begin
            case (state_q)
                SB_RUN: begin
                    if (issue_fire && dec_is_branch_jump) state_d = SB_BR_WAIT;
                    if (br_resolve) sb_error_d = 1'b1;
                end
                SB_BR_WAIT: begin
                    if (br_resolve) state_d = SB_RUN;
                end
                default: state_d = SB_RUN;
            endcase
            if (|underflow_vec) sb_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SB_RUN;
            sb_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_error_q <= sb_error_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: per-cycle expectations queued at drive time, compared at negedge.
module tb_issue_scoreboard;
    import mips_core_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      dec_valid, dec_uses_rs, dec_uses_rt, dec_uses_rw;
    mips_reg_t dec_rs_addr, dec_rt_addr, dec_rw_addr;
    logic      dec_is_branch_jump, dec_serialize, ex_ready;
    logic      issue_fire, stall;
    logic      wb_valid, kill_valid, br_resolve, flush_all;
    mips_reg_t wb_rw_addr, kill_rw_addr;
    logic      busy, sb_error;

    typedef struct {
        string name;
        logic  fire;
        logic  stall;
        logic  busy;
        logic  err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.CNT_WIDTH(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dec_valid          (dec_valid),
        .dec_uses_rs        (dec_uses_rs),
        .dec_rs_addr        (dec_rs_addr),
        .dec_uses_rt        (dec_uses_rt),
        .dec_rt_addr        (dec_rt_addr),
        .dec_uses_rw        (dec_uses_rw),
        .dec_rw_addr        (dec_rw_addr),
        .dec_is_branch_jump (dec_is_branch_jump),
        .dec_serialize      (dec_serialize),
        .ex_ready           (ex_ready),
        .issue_fire         (issue_fire),
        .stall              (stall),
        .wb_valid           (wb_valid),
        .wb_rw_addr         (wb_rw_addr),
        .kill_valid         (kill_valid),
        .kill_rw_addr       (kill_rw_addr),
        .br_resolve         (br_resolve),
        .flush_all          (flush_all),
        .busy               (busy),
        .sb_error           (sb_error)
    );

    task automatic idle();
        dec_valid = 0; dec_uses_rs = 0; dec_uses_rt = 0; dec_uses_rw = 0;
        dec_rs_addr = '0; dec_rt_addr = '0; dec_rw_addr = '0;
        dec_is_branch_jump = 0; dec_serialize = 0; ex_ready = 1;
        wb_valid = 0; wb_rw_addr = '0; kill_valid = 0; kill_rw_addr = '0;
        br_resolve = 0; flush_all = 0;
    endtask

    task automatic dec(input logic urs, input int rs, input logic urt, input int rt,
                       input logic urw, input int rw, input logic brj, input logic ser);
        dec_valid = 1;
        dec_uses_rs = urs; dec_rs_addr = 5'(rs);
        dec_uses_rt = urt; dec_rt_addr = 5'(rt);
        dec_uses_rw = urw; dec_rw_addr = 5'(rw);
        dec_is_branch_jump = brj; dec_serialize = ser;
    endtask

    // Queue the expectation for this cycle, compare at negedge, then advance past the edge.
    task automatic cyc(input string name, input logic e_fire, input logic e_stall,
                       input logic e_busy, input logic e_err);
        exp_t e;
        exp_q.push_back('{name, e_fire, e_stall, e_busy, e_err});
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (issue_fire !== e.fire) begin
            n_fail++; $display("FAIL %s issue_fire: got %b want %b", e.name, issue_fire, e.fire);
        end
        n_tests++;
        if (stall !== e.stall) begin
            n_fail++; $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
        end
        n_tests++;
        if (busy !== e.busy) begin
            n_fail++; $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
        end
        n_tests++;
        if (sb_error !== e.err) begin
            n_fail++; $display("FAIL %s sb_error: got %b want %b", e.name, sb_error, e.err);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        cyc("rst_idle", 0, 0, 0, 0);
        dec(0, 0, 0, 0, 0, 0, 0, 0); ex_ready = 0;
        cyc("rst_exnotready", 0, 1, 0, 0);
        dec(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst_plain_issue", 1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        dec(1, 1, 1, 2, 1, 8, 0, 0);
        cyc("raw_prod", 1, 0, 0, 0);
        dec(1, 8, 0, 0, 1, 10, 0, 0);
        cyc("raw_wait1", 0, 1, 1, 0);
        dec(1, 8, 0, 0, 1, 10, 0, 0);
        cyc("raw_wait2", 0, 1, 1, 0);
        dec(1, 8, 0, 0, 1, 10, 0, 0); wb_valid = 1; wb_rw_addr = 8;
        cyc("raw_wb_edge", 0, 1, 1, 0);
        dec(1, 8, 0, 0, 1, 10, 0, 0);
        cyc("raw_fire", 1, 0, 0, 0);
        wb_valid = 1; wb_rw_addr = 10;
        cyc("raw_r10_pending", 0, 0, 1, 0);
        cyc("raw_drained", 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        apply_reset();
        dec(0, 0, 0, 0, 1, 5, 0, 0); cyc("sat_w1", 1, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 5, 0, 0); cyc("sat_w2", 1, 0, 1, 0);
        dec(0, 0, 0, 0, 1, 5, 0, 0); cyc("sat_w3", 1, 0, 1, 0);
        dec(0, 0, 0, 0, 1, 5, 0, 0); cyc("sat_w4_full", 0, 1, 1, 0);
        dec(0, 0, 0, 0, 1, 5, 0, 0); wb_valid = 1; wb_rw_addr = 5;
        cyc("sat_w4_wb_same", 0, 1, 1, 0);
        dec(0, 0, 0, 0, 1, 5, 0, 0); cyc("sat_w4_fire", 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_rw_addr = 5;
            cyc("sat_drain", 0, 0, 1, 0);
        end
        cyc("sat_empty", 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        apply_reset();
        dec(1, 1, 1, 2, 0, 0, 1, 0); cyc("br_issue", 1, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 11, 0, 0); cyc("br_wait", 0, 1, 1, 0);
        dec(0, 0, 0, 0, 1, 11, 0, 0); br_resolve = 1;
        cyc("br_resolve_edge", 0, 1, 1, 0);
        dec(0, 0, 0, 0, 0, 0, 0, 0); cyc("br_after_fire", 1, 0, 0, 0);
        br_resolve = 1; cyc("br_spurious", 0, 0, 0, 0);
        cyc("br_err_set", 0, 0, 0, 1);
        cyc("br_err_sticky", 0, 0, 0, 1);
    endtask

    task automatic test_squash_flush();
        apply_reset();
        dec(0, 0, 0, 0, 1, 9, 0, 0); cyc("sq_w1", 1, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 9, 0, 0); cyc("sq_w2", 1, 0, 1, 0);
        wb_valid = 1; wb_rw_addr = 9; kill_valid = 1; kill_rw_addr = 9;
        cyc("sq_wb_kill", 0, 0, 1, 0);
        cyc("sq_r9_clear", 0, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 3, 0, 0); cyc("fl_w3", 1, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 4, 0, 0); cyc("fl_w4", 1, 0, 1, 0);
        dec(0, 0, 0, 0, 0, 0, 1, 0); cyc("fl_beq", 1, 0, 1, 0);
        dec(0, 0, 0, 0, 1, 7, 0, 0); flush_all = 1;
        cyc("fl_flush_brwait", 0, 1, 1, 0);
        cyc("fl_all_clear", 0, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 7, 0, 0); flush_all = 1; wb_valid = 1; wb_rw_addr = 12;
        cyc("fl_flush_run", 0, 0, 0, 0);
        dec(1, 7, 0, 0, 0, 0, 0, 0);
        cyc("fl_issue_discarded", 1, 0, 0, 0);
    endtask

    task automatic test_serialize_r0();
        apply_reset();
        dec(0, 0, 0, 0, 1, 6, 0, 0); cyc("ser_w6", 1, 0, 0, 0);
        dec(1, 2, 0, 0, 0, 0, 0, 1); cyc("ser_busy", 0, 1, 1, 0);
        dec(1, 2, 0, 0, 0, 0, 0, 1); wb_valid = 1; wb_rw_addr = 6;
        cyc("ser_wb_edge", 0, 1, 1, 0);
        dec(1, 2, 0, 0, 0, 0, 0, 1); cyc("ser_fire", 1, 0, 0, 0);
        dec(1, 0, 1, 0, 1, 0, 0, 0); cyc("r0_write", 1, 0, 0, 0);
        dec(1, 0, 0, 0, 1, 0, 0, 0); cyc("r0_not_busy", 1, 0, 0, 0);
        wb_valid = 1; wb_rw_addr = 0; kill_valid = 1; kill_rw_addr = 0;
        cyc("r0_wb_kill", 0, 0, 0, 0);
        cyc("r0_no_err", 0, 0, 0, 0);
    endtask

    task automatic test_underflow();
        apply_reset();
        wb_valid = 1; wb_rw_addr = 12; cyc("uf_wb_empty", 0, 0, 0, 0);
        dec(1, 12, 0, 0, 0, 0, 0, 0); cyc("uf_err_clamped", 1, 0, 0, 1);
        dec(0, 0, 0, 0, 1, 13, 0, 0); cyc("uf_w13", 1, 0, 0, 1);
        wb_valid = 1; wb_rw_addr = 13; kill_valid = 1; kill_rw_addr = 13;
        cyc("uf_double_dec", 0, 0, 1, 1);
        cyc("uf_r13_zero", 0, 0, 0, 1);
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        dec(0, 0, 0, 0, 1, 2, 0, 0); cyc("mr_w2", 1, 0, 0, 0);
        dec(0, 0, 0, 0, 1, 3, 0, 0); cyc("mr_w3", 1, 0, 1, 0);
        wb_valid = 1; wb_rw_addr = 20; cyc("mr_underflow", 0, 0, 1, 0);
        dec(0, 0, 0, 0, 0, 0, 1, 0); cyc("mr_beq", 1, 0, 1, 1);
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        dec(1, 2, 1, 3, 0, 0, 0, 0); ex_ready = 0;
        cyc("mr_after_rst_exnr", 0, 1, 0, 0);
        dec(1, 2, 1, 3, 0, 0, 0, 0);
        cyc("mr_after_rst_fire", 1, 0, 0, 0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_saturation();
        test_branch();
        test_squash_flush();
        test_serialize_r0();
        test_underflow();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
